// File: rtl/usb_rx_timer.sv
// usb_rx_timer: bit/word timing recovery for the USB receive path.
// A phase counter is re-zeroed on every line transition and a bit is sampled
// when it reaches SAMPLE_PHASE. Each sample either shifts a data bit, drops a
// stuffed zero, or flags a stuffing violation. Shifted bits are counted into
// words, and EOP is reported to the RX controller.
// Sampled outputs (shift_enable, stuff_skip, pkt_done) are decoded
// combinationally from the registered state. word_rcvd is registered, so it
// pulses the cycle after the last shift of a word. Deasserting rcving clears
// every counter and flag on the next edge and suppresses all pulses in that
// cycle.
module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int WORD_BITS    = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       d_orig,
  input  logic       eop,
  output logic       shift_enable,
  output logic       stuff_skip,
  output logic       word_rcvd,
  output logic       pkt_done,
  output logic       bit_err,
  output logic [5:0] word_count
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [PW-1:0] PHASE_MAX    = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [BW-1:0] BIT_MAX      = BW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  phase;
  logic [2:0]     ones;
  logic [BW-1:0]  bit_cnt;
  logic           sample;
  logic           viol;
  logic           word_last;

  // Decode the sample event and its outcome from the registered state.
  always_comb begin
    sample       = rcving && (state == ACTIVE) && (phase == PHASE_SAMPLE) && !eop;
    shift_enable = sample && (ones != 3'd6);
    stuff_skip   = sample && (ones == 3'd6) && !d_orig;
    viol         = sample && (ones == 3'd6) && d_orig;
    pkt_done     = rcving && (state == ACTIVE) && eop;
    word_last    = shift_enable && (bit_cnt == BIT_MAX);
  end

  // Next-state logic; dropping rcving overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (!rcving) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (d_edge) state_nxt = ACTIVE;
        ACTIVE:  if (eop) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Phase counter: held at 0 outside ACTIVE (so entry loads 0), re-phased on edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                     phase <= '0;
    else if (!rcving || (state != ACTIVE) || d_edge) phase <= '0;
    else if (phase == PHASE_MAX)                    phase <= '0;
    else                                            phase <= phase + 1'b1;
  end

  // Consecutive-ones counter; a violation holds it at 6.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            ones <= '0;
    else if (!rcving)      ones <= '0;
    else if (shift_enable) ones <= d_orig ? ones + 3'd1 : 3'd0;
    else if (stuff_skip)   ones <= '0;
  end

  // Bit-in-word counter, advanced only by real data shifts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            bit_cnt <= '0;
    else if (!rcving)      bit_cnt <= '0;
    else if (word_last)    bit_cnt <= '0;
    else if (shift_enable) bit_cnt <= bit_cnt + 1'b1;
  end

  // Word-complete pulse, one cycle after the last shift of a word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) word_rcvd <= 1'b0;
    else        word_rcvd <= rcving && word_last;
  end

  // Sticky stuffing-violation flag, cleared only when rcving drops.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       bit_err <= 1'b0;
    else if (!rcving) bit_err <= 1'b0;
    else if (viol)    bit_err <= 1'b1;
  end

  // Saturating count of words received in this packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                 word_count <= '0;
    else if (!rcving)                           word_count <= '0;
    else if (word_rcvd && (word_count != 6'd63)) word_count <= word_count + 6'd1;
  end

endmodule

// File: tb/tb_usb_rx_timer.sv
// tb_usb_rx_timer: table-driven packets, hand-written corner sequences and
// random packets checked against a bit-stream model of USB bit stuffing.
module tb_usb_rx_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rcving;
  logic       d_edge;
  logic       d_orig;
  logic       eop;
  logic       shift_enable;
  logic       stuff_skip;
  logic       word_rcvd;
  logic       pkt_done;
  logic       bit_err;
  logic [5:0] word_count;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters kept by the monitor.
  int cnt_shift = 0;
  int cnt_stuff = 0;
  int cnt_word  = 0;

  // Bit-stream model: current run of ones, data bits in the open word,
  // words completed in this packet, and the sticky violation flag.
  int   m_run;
  int   m_bits;
  int   m_words;
  logic m_err;

  typedef struct {
    int          n_bits;
    logic [31:0] data;
    bit          drift;
    int          exp_shift;
    int          exp_stuff;
    int          exp_word;
    logic        exp_err;
    logic [5:0]  exp_wc;
  } vec_t;

  vec_t vecs[6];

  usb_rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rcving       (rcving),
    .d_edge       (d_edge),
    .d_orig       (d_orig),
    .eop          (eop),
    .shift_enable (shift_enable),
    .stuff_skip   (stuff_skip),
    .word_rcvd    (word_rcvd),
    .pkt_done     (pkt_done),
    .bit_err      (bit_err),
    .word_count   (word_count)
  );

  // Clock.
  always #5 clk = ~clk;

  // Monitor: count output pulses away from the active edge.
  always @(negedge clk) begin
    if (shift_enable) cnt_shift++;
    if (stuff_skip)   cnt_stuff++;
    if (word_rcvd)    cnt_word++;
  end

  // Watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] sat63(input int n);
    return (n > 63) ? 6'd63 : 6'(n);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drop rcving for two cycles, confirm everything is cleared, reset the model.
  task automatic start_packet();
    rcving = 1'b0; d_edge = 1'b0; eop = 1'b0; d_orig = 1'b0;
    @(negedge clk);
    check("abort_shift", shift_enable, 0);
    check("abort_pkt_done", pkt_done, 0);
    next_cycle();
    @(negedge clk);
    check("clr_word_count", word_count, 0);
    check("clr_bit_err", bit_err, 0);
    check("clr_word_rcvd", word_rcvd, 0);
    next_cycle();
    m_run = 0; m_bits = 0; m_words = 0; m_err = 1'b0;
  endtask

  // Drive one bit period of len clocks: edge in the first cycle, d_orig held.
  // The edge cycle is followed by phases 0,1,2,3, so the sample lands at
  // offset 4, word_rcvd at offset 5, and word_count settles by offset 6.
  task automatic drive_bit(input logic b, input int len);
    logic do_shift, do_stuff, do_viol, word_done, err_before;
    err_before = m_err;
    do_shift = 1'b0; do_stuff = 1'b0; do_viol = 1'b0; word_done = 1'b0;
    if (m_run == 6) begin
      if (b) do_viol = 1'b1;
      else begin
        do_stuff = 1'b1;
        m_run = 0;
      end
    end else begin
      do_shift = 1'b1;
      m_run = b ? m_run + 1 : 0;
      m_bits++;
      if (m_bits == 16) begin
        m_bits = 0;
        word_done = 1'b1;
        m_words++;
      end
    end
    if (do_viol) m_err = 1'b1;
    for (int off = 0; off < len; off++) begin
      rcving = 1'b1; eop = 1'b0; d_edge = (off == 0); d_orig = b;
      @(negedge clk);
      check("shift_enable", shift_enable, do_shift && (off == 4));
      check("stuff_skip", stuff_skip, do_stuff && (off == 4));
      check("word_rcvd", word_rcvd, word_done && (off == 5));
      check("bit_err", bit_err, err_before || (do_viol && off >= 5));
      check("pkt_done_idle", pkt_done, 0);
      if (off == len - 1) check("word_count", word_count, sat63(m_words));
      next_cycle();
    end
  endtask

  // One-cycle EOP while ACTIVE.
  task automatic do_eop();
    rcving = 1'b1; d_edge = 1'b0; eop = 1'b1;
    @(negedge clk);
    check("eop_pkt_done", pkt_done, 1);
    check("eop_shift", shift_enable, 0);
    next_cycle();
    eop = 1'b0;
    @(negedge clk);
    check("eop_pkt_done_once", pkt_done, 0);
    next_cycle();
  endtask

  initial begin
    int   b_shift, b_stuff, b_word, len, n;
    logic bit_v;

    vecs[0] = '{16, 32'h0000A5C3, 1'b0, 16, 0, 1, 1'b0, 6'd1};
    vecs[1] = '{17, 32'h0001F800, 1'b0, 16, 1, 1, 1'b0, 6'd1};
    vecs[2] = '{7,  32'h0000007F, 1'b0, 6,  0, 0, 1'b1, 6'd0};
    vecs[3] = '{16, 32'h0000A5C3, 1'b1, 16, 0, 1, 1'b0, 6'd1};
    vecs[4] = '{32, 32'h00000000, 1'b0, 32, 0, 2, 1'b0, 6'd2};
    vecs[5] = '{14, 32'h00003F7E, 1'b0, 12, 2, 0, 1'b0, 6'd0};

    // Reset.
    n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; d_orig = 1'b0; eop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_shift", shift_enable, 0);
    check("rst_stuff", stuff_skip, 0);
    check("rst_word_rcvd", word_rcvd, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_bit_err", bit_err, 0);
    check("rst_word_count", word_count, 0);
    n_rst = 1'b1;
    next_cycle();

    // Table-driven packets.
    for (int i = 0; i < 6; i++) begin
      start_packet();
      b_shift = cnt_shift; b_stuff = cnt_stuff; b_word = cnt_word;
      for (int j = 0; j < vecs[i].n_bits; j++) begin
        bit_v = vecs[i].data[vecs[i].n_bits - 1 - j];
        len = !vecs[i].drift ? 8 : ((j < vecs[i].n_bits / 2) ? 7 : 9);
        drive_bit(bit_v, len);
      end
      check($sformatf("vec%0d_shifts", i), cnt_shift - b_shift, vecs[i].exp_shift);
      check($sformatf("vec%0d_stuffs", i), cnt_stuff - b_stuff, vecs[i].exp_stuff);
      check($sformatf("vec%0d_words", i), cnt_word - b_word, vecs[i].exp_word);
      check($sformatf("vec%0d_bit_err", i), bit_err, vecs[i].exp_err);
      check($sformatf("vec%0d_word_count", i), word_count, vecs[i].exp_wc);
    end

    // EOP after 20 bits: one word only, pkt_done pulses, DONE holds the count.
    start_packet();
    for (int j = 0; j < 20; j++) drive_bit(1'b0, 8);
    b_word = cnt_word;
    do_eop();
    repeat (10) next_cycle();
    check("eop20_no_second_word", cnt_word - b_word, 0);
    check("eop20_word_count", word_count, 1);

    // EOP in the sample cycle wins; DONE ignores further edges.
    start_packet();
    b_shift = cnt_shift;
    for (int off = 0; off < 12; off++) begin
      rcving = 1'b1; d_orig = 1'b1; d_edge = (off == 0) || (off == 7); eop = (off == 4);
      @(negedge clk);
      if (off == 4) begin
        check("eop_vs_sample_shift", shift_enable, 0);
        check("eop_vs_sample_pkt_done", pkt_done, 1);
      end
      next_cycle();
    end
    eop = 1'b0;
    check("done_no_shift", cnt_shift - b_shift, 0);

    // Word pending when EOP arrives still issues word_rcvd.
    start_packet();
    for (int j = 0; j < 15; j++) drive_bit(1'b0, 8);
    for (int off = 0; off < 8; off++) begin
      rcving = 1'b1; d_orig = 1'b0; d_edge = (off == 0); eop = (off == 5);
      @(negedge clk);
      if (off == 4) check("pend_last_shift", shift_enable, 1);
      if (off == 5) begin
        check("pend_word_rcvd", word_rcvd, 1);
        check("pend_pkt_done", pkt_done, 1);
      end
      if (off == 7) check("pend_word_count", word_count, 1);
      next_cycle();
    end

    // rcving dropped mid-word after a violation: no pulse, flags cleared.
    start_packet();
    for (int j = 0; j < 7; j++) drive_bit(1'b1, 8);
    for (int off = 0; off < 6; off++) begin
      d_orig = 1'b0; d_edge = (off == 0); eop = 1'b0; rcving = (off < 4);
      @(negedge clk);
      if (off == 4) begin
        check("drop_no_stuff", stuff_skip, 0);
        check("drop_no_shift", shift_enable, 0);
      end
      if (off == 5) begin
        check("drop_bit_err", bit_err, 0);
        check("drop_word_count", word_count, 0);
      end
      next_cycle();
    end
    start_packet();
    for (int j = 0; j < 16; j++) drive_bit(vecs[0].data[15 - j], 8);
    check("after_drop_word_count", word_count, 1);

    // Asynchronous reset in the middle of a sample cycle.
    start_packet();
    for (int j = 0; j < 20; j++) drive_bit(1'b0, 8);
    for (int off = 0; off < 5; off++) begin
      rcving = 1'b1; d_orig = 1'b0; d_edge = (off == 0); eop = 1'b0;
      if (off < 4) next_cycle();
    end
    #1;
    n_rst = 1'b0;
    #1;
    check("arst_shift", shift_enable, 0);
    check("arst_word_count", word_count, 0);
    check("arst_bit_err", bit_err, 0);
    check("arst_word_rcvd", word_rcvd, 0);
    check("arst_pkt_done", pkt_done, 0);
    check("arst_stuff", stuff_skip, 0);
    @(negedge clk);
    n_rst = 1'b1;
    next_cycle();
    start_packet();
    for (int j = 0; j < 16; j++) drive_bit(1'b1 ^ j[0], 8);
    check("arst_restart_word_count", word_count, 1);

    // Saturation: 64 words of zeros.
    start_packet();
    b_word = cnt_word;
    for (int j = 0; j < 1024; j++) drive_bit(1'b0, 7);
    check("sat_word_pulses", cnt_word - b_word, 64);
    check("sat_word_count", word_count, 63);

    // Random packets with drifting bit periods and a bias towards ones.
    for (int p = 0; p < 6; p++) begin
      start_packet();
      n = $urandom_range(20, 60);
      for (int j = 0; j < n; j++) begin
        bit_v = ($urandom_range(0, 9) < 7);
        drive_bit(bit_v, $urandom_range(7, 9));
      end
      do_eop();
      check("rand_word_count", word_count, sat63(m_words));
      check("rand_bit_err", bit_err, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
